uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- 8N1 UART transmitter that drives the top-level `uart_txd` pin. It is the counterpart of the serial stream the CPU's receiver consumes.
- Accepts bytes from the CPU peripheral bus through a valid/ready handshake.
- Buffers bytes in a small FIFO and serialises them LSB first at a fixed baud rate derived from the 50 MHz system clock.

Parameters:
- CLKS_PER_BIT, 5208, system clocks per serial bit (50 MHz / 9600 baud); legal range 16..65535.
- FIFO_DEPTH, 4, byte entries; power of two, 2..16.
- CNT_W, 3, width of fifo_count; equals log2(FIFO_DEPTH)+1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- tx_data  input  8  byte to transmit.
- tx_valid  input  1  tx_data is valid this cycle.
- tx_ready  output  1  FIFO can accept a byte; high when not full.
- uart_txd  output  1  serial line; idle high.
- tx_busy  output  1  a frame is on the line or the FIFO is non-empty.
- fifo_count  output  CNT_W  number of bytes queued (excludes the byte being shifted).

Behaviour:
- Reset (asynchronous, immediate):
  - uart_txd=1, tx_ready=1, tx_busy=0, fifo_count=0.
  - FSM=IDLE; read/write pointers, bit counter and baud counter are all 0.
- Reset asserted mid-frame: uart_txd returns to 1 at once, the frame is aborted, and FIFO contents are discarded.
- Push:
  - A byte is written on a rising edge with tx_valid && tx_ready.
  - tx_ready = !full, computed from registered state only; there is no combinational path from tx_valid.
  - tx_valid while full: the byte is ignored and no state changes.
- Pointers: wrap modulo FIFO_DEPTH, with an extra MSB to distinguish full from empty.
- FSM states: IDLE, START, DATA, STOP (plus PARITY with the option enabled).
  - IDLE: if FIFO is non-empty, pop the head into the shift register, clear the baud counter, and go to START. uart_txd goes 0 on the next cycle.
  - START: drive 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: drive shift[0] for CLKS_PER_BIT cycles, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: drive 1 for CLKS_PER_BIT cycles. On completion, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Frame length: exactly 10*CLKS_PER_BIT cycles.
  - Latency from the accepting push edge (FSM in IDLE, FIFO empty) to the falling start edge is 2 cycles.
- Simultaneous push and pop in the same cycle: both take effect, and fifo_count is unchanged.
  - Pop frees a slot only from the next cycle; tx_ready is not bypassed.
- Baud counter: counts 0..CLKS_PER_BIT-1, and the bit boundary is the cycle the counter equals CLKS_PER_BIT-1.
  - The counter is held at 0 in IDLE.
- tx_busy = (state != IDLE) || (fifo_count != 0), registered.
- uart_txd is driven from a flop (glitch-free).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame becomes 11*CLKS_PER_BIT cycles.
- Undefined: no PARITY state, no parity logic, and the 8N1 frame is exactly as above.

Decomposition:
- Shared package `uart_pkg`:
  - FSM state encoding typedef (IDLE/START/DATA/PARITY/STOP).
  - Constants: UART_DATA_BITS=8, UART_CLK_HZ=50_000_000, UART_BAUD=9600, UART_CLKS_PER_BIT default.
  - The receiver reuses these same constants.
- One sub-module, `uart_baud_tick`:
  - Enable-gated counter with a clear input.
  - Emits a one-cycle tick at CLKS_PER_BIT-1.
  - Shared with the receiver block.
- The FIFO stays inline as a register array plus pointers.

Test Plan (CLKS_PER_BIT=5208, 20 ns clock):
- Single byte: push 0x38 while idle.
  - Start edge appears 2 cycles later.
  - Line reads 0, then 0,0,0,1,1,1,0,0 (LSB first), then 1.
  - Each bit is 104.16 us; tx_busy drops 1 cycle after stop completes.
- Back-to-back: push 0x38 then 0x49 on consecutive cycles.
  - Second start bit begins exactly 52080 cycles after the first start edge.
  - No idle gap; fifo_count goes 1→0 when the second byte pops.
- Full FIFO: push 6 bytes 0x01..0x06 in 6 consecutive cycles while idle.
  - 0x01 pops at the start of the first frame.
  - 0x02..0x05 fill the FIFO; tx_ready goes low with fifo_count=4.
  - 0x06 is dropped.
  - Line emits exactly 0x01..0x05.
- Reset mid-frame: assert reset during DATA bit 3 of 0xA5.
  - uart_txd goes 1 within the same cycle.
  - tx_busy=0 and fifo_count=0.
  - After release, pushing 0x5A produces a clean 0x5A frame.
- Simultaneous push/pop: with FIFO holding 1 byte, push a byte on the exact cycle STOP completes.
  - fifo_count stays 1 and both bytes are transmitted in order.
- Parity (UART_TX_PARITY_EN defined): push 0x07.
  - Frame is start, 1,1,1,0,0,0,0,0, parity=1, stop.
  - Total frame is 57288 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and FSM state type, used by the transmitter and receiver.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS    = 8;
  localparam int unsigned UART_CLK_HZ       = 50_000_000;
  localparam int unsigned UART_BAUD         = 9600;
  localparam int unsigned UART_CLKS_PER_BIT = UART_CLK_HZ / UART_BAUD;  // 5208

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic uart_even_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Enable-gated bit-period counter with synchronous clear; o_tick marks the last cycle
// of each bit period (counter == CLKS_PER_BIT-1).
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == LastCnt);

  // Count while enabled, wrapping to 0 on the tick cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter with a small byte FIFO in front of the serialiser.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [UART_DATA_BITS-1:0] i_tx_data,
  input  logic                      i_tx_valid,
  output logic                      o_tx_ready,
  output logic                      o_uart_txd,
  output logic                      o_tx_busy,
  output logic [CNT_W-1:0]          o_fifo_count
);

  localparam int unsigned AddrW = CNT_W - 1;

  // FIFO storage; pointers carry one extra MSB so full and empty differ.
  logic [UART_DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [CNT_W-1:0]          r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]          w_count;
  logic                      w_full, w_empty, w_push, w_pop;

  uart_state_e               r_state, w_state_d;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [2:0]                r_bit_idx;
  logic                      r_txd, w_txd_d;
  logic                      r_busy;
  logic                      w_baud_en, w_baud_clr, w_tick;
`ifdef UART_TX_PARITY_EN
  logic                      r_parity;
`endif

  assign w_count      = r_wr_ptr - r_rd_ptr;
  assign w_full       = (w_count == CNT_W'(FIFO_DEPTH));
  assign w_empty      = (w_count == '0);
  assign w_push       = i_tx_valid && !w_full;
  assign o_tx_ready   = !w_full;
  assign o_fifo_count = w_count;
  assign o_uart_txd   = r_txd;
  assign o_tx_busy    = r_busy;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_en   (w_baud_en),
    .i_clr  (w_baud_clr),
    .o_tick (w_tick)
  );

  // FIFO storage write; contents need no reset since the pointers gate every read.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AddrW-1:0]] <= i_tx_data;
    end
  end

  // FIFO pointer update; push and pop may both occur in one cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= StIdle;
    else         r_state <= w_state_d;
  end

  // Next-state, pop request and baud-counter control.
  always_comb begin
    w_state_d  = r_state;
    w_pop      = 1'b0;
    w_baud_en  = 1'b1;
    w_baud_clr = 1'b0;
    case (r_state)
      StIdle: begin
        w_baud_en  = 1'b0;
        w_baud_clr = 1'b1;
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_state_d = StStart;
        end
      end
      StStart: if (w_tick) w_state_d = StData;
      StData: begin
        if (w_tick && (r_bit_idx == 3'(UART_DATA_BITS - 1))) begin
`ifdef UART_TX_PARITY_EN
          w_state_d = StParity;
`else
          w_state_d = StStop;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: if (w_tick) w_state_d = StStop;
`endif
      StStop: begin
        if (w_tick) begin
          // Chain straight into the next frame when a byte is waiting.
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_state_d = StStart;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Line level for the current state; registered one cycle later.
  always_comb begin
    w_txd_d = 1'b1;
    case (r_state)
      StStart:  w_txd_d = 1'b0;
      StData:   w_txd_d = r_shift[0];
`ifdef UART_TX_PARITY_EN
      StParity: w_txd_d = r_parity;
`endif
      default:  w_txd_d = 1'b1;
    endcase
  end

  // Shift register, bit index, line flop and busy flag.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      if (w_pop) begin
        r_shift   <= r_mem[r_rd_ptr[AddrW-1:0]];
        r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
        r_parity  <= uart_even_parity(r_mem[r_rd_ptr[AddrW-1:0]]);
`endif
      end else if ((r_state == StData) && w_tick) begin
        r_shift   <= r_shift >> 1;
        r_bit_idx <= r_bit_idx + 1'b1;
      end
      r_txd  <= w_txd_d;
      r_busy <= (r_state != StIdle) || !w_empty;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: timeline model of the line plus a UART decoder.
module tb_uart_tx_fifo;

  localparam int C     = 16;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif
  localparam int WAIT_MAX = 400;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, uart_txd, tx_busy;
  logic [2:0] fifo_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  uart_tx_fifo #(
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH  (DEPTH),
    .CNT_W       (3)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_tx_data   (tx_data),
    .i_tx_valid  (tx_valid),
    .o_tx_ready  (tx_ready),
    .o_uart_txd  (uart_txd),
    .o_tx_busy   (tx_busy),
    .o_fifo_count(fifo_count)
  );

  always #10 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: accepted bytes queue up; each popped byte owns a FRAME*C-cycle line window that
  // begins one cycle after its pop edge. A pop happens on any edge where the queue is
  // non-empty and the previous frame window (measured from its pop edge) has elapsed.
  logic [7:0] m_q[$];
  logic [7:0] m_byte = '0;
  bit         m_have = 1'b0;
  int         m_n = 0;
  int         m_p = 0;
  bit         m_busy = 1'b0;

  initial forever begin
    int  pre;
    bit  do_pop;
    @(posedge clk or posedge reset);
    if (reset) begin
      m_q.delete();
      m_have = 1'b0;
      m_busy = 1'b0;
    end else begin
      m_n    = m_n + 1;
      pre    = m_q.size();
      m_busy = (m_have && (m_n - 1 < m_p + FRAME * C)) || (pre != 0);
      do_pop = (pre != 0) && (!m_have || (m_n >= m_p + FRAME * C));
      if (do_pop) begin
        m_byte = m_q.pop_front();
        m_have = 1'b1;
        m_p    = m_n;
      end
      if (tx_valid && (pre < DEPTH)) m_q.push_back(tx_data);
    end
  end

  // Compare process: every cycle out of reset, outputs must match the model.
  initial forever begin
    int   o, k;
    logic exp_txd;
    @(negedge clk);
    if (!reset) begin
      exp_txd = 1'b1;
      o = m_n - m_p - 1;
      if (m_have && (o >= 0) && (o < FRAME * C)) begin
        k = o / C;
        if (k == 0)              exp_txd = 1'b0;
        else if (k <= 8)         exp_txd = m_byte[k-1];
        else if (k == FRAME - 1) exp_txd = 1'b1;
        else                     exp_txd = ^m_byte;
      end
      check("txd",   32'(uart_txd),   32'(exp_txd));
      check("ready", 32'(tx_ready),   32'(m_q.size() < DEPTH));
      check("count", 32'(fifo_count), 32'(m_q.size()));
      check("busy",  32'(tx_busy),    32'(m_busy));
    end
  end

  // Independent line decoder sampling at mid-bit.
  logic [7:0] rx_q[$];
  logic       rx_par_q[$];
  initial forever begin
    bit         active;
    int         t, k;
    logic [7:0] sh;
    @(negedge clk or posedge reset);
    if (reset) begin
      active = 1'b0;
    end else if (!active) begin
      if (uart_txd === 1'b0) begin
        active = 1'b1;
        t = 0;
        sh = '0;
      end
    end else begin
      t = t + 1;
      if (t % C == C / 2) begin
        k = t / C;
        if (k == 0) begin
          check("rx_start", 32'(uart_txd), 32'd0);
        end else if (k <= 8) begin
          sh[k-1] = uart_txd;
        end else if (k == FRAME - 1) begin
          check("rx_stop", 32'(uart_txd), 32'd1);
          rx_q.push_back(sh);
          active = 1'b0;
        end else begin
          check("rx_parity", 32'(uart_txd), 32'(^sh));
          rx_par_q.push_back(uart_txd);
        end
      end
    end
  end

  task automatic push1(input logic [7:0] b, output int e);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    e = cyc;
    tx_valid = 1'b0;
  endtask

  task automatic wait_start(output int t);
    for (int i = 0; i < WAIT_MAX && uart_txd !== 1'b0; i++) @(negedge clk);
    check("start_seen", 32'(uart_txd), 32'd0);
    t = cyc;
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 6 * FRAME * C && rx_q.size() < n; i++) @(negedge clk);
    check("rx_count", 32'(rx_q.size()), 32'(n));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < WAIT_MAX && tx_busy !== 1'b0; i++) @(negedge clk);
    check("idle_seen", 32'(tx_busy), 32'd0);
  endtask

  initial begin
    int e, t, t2;
    repeat (3) @(negedge clk);
    #1;
    check("rst_txd",   32'(uart_txd),   32'd1);
    check("rst_ready", 32'(tx_ready),   32'd1);
    check("rst_busy",  32'(tx_busy),    32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Single byte 0x38: start edge 2 cycles after push; busy lasts one frame past start.
    push1(8'h38, e);
    wait_start(t);
    check("start_latency", 32'(t - e), 32'd2);
    wait_rx(1);
    check("single_byte", 32'(rx_q[0]), 32'h38);
    wait_idle();
    check("busy_fall", 32'(cyc - t), 32'(FRAME * C));
    repeat (5) @(negedge clk);

    // Back-to-back 0x38, 0x49: second start exactly one frame after the first.
    rx_q.delete();
    tx_valid = 1'b1;
    tx_data  = 8'h38;
    @(negedge clk);
    tx_data  = 8'h49;
    @(negedge clk);
    tx_valid = 1'b0;
    check("b2b_count", 32'(fifo_count), 32'd1);
    wait_start(t);
    repeat (FRAME * C - 2) @(negedge clk);
    wait_start(t2);
    check("b2b_gap", 32'(t2 - t), 32'(FRAME * C));
    wait_rx(2);
    check("b2b_byte0", 32'(rx_q[0]), 32'h38);
    check("b2b_byte1", 32'(rx_q[1]), 32'h49);
    wait_idle();
    repeat (5) @(negedge clk);

    // Full FIFO: 0x01..0x06 pushed back to back; 0x06 is dropped.
    rx_q.delete();
    for (int b = 1; b <= 6; b++) begin
      tx_valid = 1'b1;
      tx_data  = 8'(b);
      @(negedge clk);
    end
    tx_valid = 1'b0;
    check("full_ready", 32'(tx_ready),   32'd0);
    check("full_count", 32'(fifo_count), 32'd4);
    wait_rx(5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++) check("full_byte", 32'(rx_q[i]), 32'(i + 1));
    repeat (FRAME * C + 20) @(negedge clk);
    check("full_total", 32'(rx_q.size()), 32'd5);

    // Reset during data bit 3 of 0xA5, then a clean 0x5A frame.
    rx_q.delete();
    push1(8'hA5, e);
    wait_start(t);
    repeat (4 * C + C / 2) @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("abort_txd",   32'(uart_txd),   32'd1);
    check("abort_busy",  32'(tx_busy),    32'd0);
    check("abort_count", 32'(fifo_count), 32'd0);
    check("abort_ready", 32'(tx_ready),   32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_rx", 32'(rx_q.size()), 32'd0);
    push1(8'h5A, e);
    wait_rx(1);
    check("after_reset", 32'(rx_q[0]), 32'h5A);
    wait_idle();
    repeat (5) @(negedge clk);

    // Push on the exact edge the stop bit completes while one byte is queued.
    rx_q.delete();
    tx_valid = 1'b1;
    tx_data  = 8'h11;
    @(negedge clk);
    tx_data  = 8'h22;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_start(t);
    repeat (FRAME * C - 2) @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'h33;
    @(negedge clk);
    tx_valid = 1'b0;
    check("simul_count", 32'(fifo_count), 32'd1);
    check("simul_line",  32'(uart_txd),   32'd1);
    @(negedge clk);
    check("simul_start", 32'(uart_txd),   32'd0);
    wait_rx(3);
    check("simul_byte0", 32'(rx_q[0]), 32'h11);
    check("simul_byte1", 32'(rx_q[1]), 32'h22);
    check("simul_byte2", 32'(rx_q[2]), 32'h33);
    wait_idle();

`ifdef UART_TX_PARITY_EN
    // 0x07 has three ones, so the even-parity bit is 1 and the frame spans 11 bits.
    rx_q.delete();
    rx_par_q.delete();
    repeat (5) @(negedge clk);
    push1(8'h07, e);
    wait_start(t);
    wait_idle();
    check("par_frame", 32'(cyc - t), 32'(11 * C));
    wait_rx(1);
    check("par_byte", 32'(rx_q[0]), 32'h07);
    check("par_bit",  32'(rx_par_q.size() > 0 ? rx_par_q[0] : 1'b0), 32'd1);
`endif

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
